// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MD_ITER = 32;
  localparam logic [31:0] MD_DIV0_LO = '1;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_NONE7 = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } md_state_t;

  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// One iteration of the mul/div datapath: shift-add multiply or restoring divide
// on a 64-bit accumulator ({upper, multiplier} or {remainder, dividend/quotient}).
module ex_muldiv_core (
  input  logic [63:0] acc,
  input  logic [31:0] opb,
  input  logic        is_div,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] diff;

  always_comb begin
    sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    // bit 32 of diff is the borrow: shifted remainder smaller than divisor
    diff = acc[63:31] - {1'b0, opb};
    if (is_div)
      acc_next = diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    else
      acc_next = {sum, acc[31:1]};
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU with HI/LO and pipeline stall.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (divides stay iterative).
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic [2:0]  ex_mdop,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_op_t      op;
  md_state_t   state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [31:0] opb;
  logic        div_op;
  logic        neg_q;
  logic        neg_r;

  logic        is_mul, is_div, is_signed, div0;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign op = md_op_t'(ex_mdop);

  always_comb begin
    is_mul    = (op == MD_MULT) || (op == MD_MULTU);
    is_div    = (op == MD_DIV)  || (op == MD_DIVU);
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    div0      = is_div && (ex_b == '0);
    a_mag     = md_mag(ex_a, is_signed);
    b_mag     = md_mag(ex_b, is_signed);
  end

  assign stall = rst & ~flush &
                 (((state == S_IDLE) & (is_mul | is_div)) | (state == S_BUSY));

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  always_comb begin
    if (op == MD_MULT)
      fast_prod = 64'($signed(ex_a) * $signed(ex_b));
    else
      fast_prod = 64'(ex_a) * 64'(ex_b);
  end
`endif

  ex_muldiv_core u_core (
    .acc      (acc),
    .opb      (opb),
    .is_div   (div_op),
    .acc_next (acc_next)
  );

  // Sign correction applied to the final step's result as it is committed
  always_comb begin
    prod_fix = neg_q ? -acc_next : acc_next;
    quo_fix  = neg_q ? -acc_next[31:0]  : acc_next[31:0];
    rem_fix  = neg_r ? -acc_next[63:32] : acc_next[63:32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (!flush) begin
            if (op == MD_MTHI) begin
              hi <= ex_a;
            end else if (op == MD_MTLO) begin
              lo <= ex_a;
            end else if (div0) begin
              hi    <= ex_a;
              lo    <= MD_DIV0_LO;
              done  <= 1'b1;
              state <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (is_mul) begin
              {hi, lo} <= fast_prod;
              done     <= 1'b1;
              state    <= S_DONE;
`endif
            end else if (is_mul || is_div) begin
              acc    <= {32'd0, is_div ? a_mag : b_mag};
              opb    <= is_div ? b_mag : a_mag;
              div_op <= is_div;
              neg_q  <= is_signed & (ex_a[31] ^ ex_b[31]);
              neg_r  <= is_signed & is_div & ex_a[31];
              cnt    <= '0;
              state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(ITER - 1)) begin
              if (div_op) begin
                hi <= rem_fix;
                lo <= quo_fix;
              end else begin
                {hi, lo} <= prod_fix;
              end
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: cycle-level reference model plus literal result checks.
module tb_ex_muldiv;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ex_a = '0;
  logic [31:0] ex_b = '0;
  logic [2:0]  ex_mdop = '0;
  logic        stall, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  ex_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .ex_a    (ex_a),
    .ex_b    (ex_b),
    .ex_mdop (ex_mdop),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [2:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  // Architectural result {hi,lo} straight from the arithmetic definition
  function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sp;
    int sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      OP_MULT: begin
        sp = 64'(sa) * 64'(sb);
        return sp;
      end
      OP_MULTU: return 64'(a) * 64'(b);
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit one_cycle(input logic [2:0] op, input logic [31:0] b);
`ifdef MULDIV_FAST_MUL_EN
    if (op == OP_MULT || op == OP_MULTU) return 1'b1;
`endif
    return (op == OP_DIV || op == OP_DIVU) && (b == 32'd0);
  endfunction

  // Reference: m_rem counts BUSY cycles still to run for an op in flight
  int          m_rem = 0;
  bit          m_in_done = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem = 0; m_in_done = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_in_done) begin
        m_in_done = 1'b0;
      end else if (m_rem > 0) begin
        if (flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            {m_hi, m_lo} = m_res; m_done = 1'b1; m_in_done = 1'b1;
          end
        end
      end else if (!flush) begin
        if (ex_mdop == OP_MTHI) m_hi = ex_a;
        else if (ex_mdop == OP_MTLO) m_lo = ex_a;
        else if (is_md(ex_mdop)) begin
          m_res = ref_hilo(ex_mdop, ex_a, ex_b);
          if (one_cycle(ex_mdop, ex_b)) begin
            {m_hi, m_lo} = m_res; m_done = 1'b1; m_in_done = 1'b1;
          end else m_rem = 32;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = rst && !flush && (m_rem > 0 || (!m_in_done && is_md(ex_mdop)));
    check("stall", 64'(stall), 64'(exp_stall));
    check("done",  64'(done),  64'(m_done));
    check("hi",    64'(hi),    64'(m_hi));
    check("lo",    64'(lo),    64'(m_lo));
    if (done === 1'b1) done_cnt++;
  end

  // Hold the op in EX until it leaves (first cycle without stall); returns stall cycles
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nstall);
    logic s;
    bit left;
    ex_mdop = op; ex_a = a; ex_b = b;
    nstall = 0;
    left = 1'b0;
    for (int i = 0; i < 100 && !left; i++) begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      #1;
      if (s === 1'b1) nstall++;
      else left = 1'b1;
    end
    if (!left) check("op_timeout", 64'(nstall), 64'd0);
    ex_mdop = OP_NONE;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n, d0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    check("multu_max_nstall", 64'(n), 64'(MUL_STALL));
    check("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
    check("multu_max_lo", 64'(lo), 64'h00000001);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, n);
    check("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

    run_op(OP_MULT, 32'h80000000, 32'h80000000, n);
    check("mult_min_hi", 64'(hi), 64'h40000000);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, n);
    check("div_neg_nstall", 64'(n), 64'd33);
    check("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, n);
    check("div_negb_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_negb_hi", 64'(hi), 64'h00000001);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    check("div_ovf_lo", 64'(lo), 64'h80000000);
    check("div_ovf_hi", 64'(hi), 64'h00000000);

    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd3, n);
    check("divu_lo", 64'(lo), 64'h55555555);
    check("divu_hi", 64'(hi), 64'h00000000);

    run_op(OP_DIVU, 32'd100, 32'd0, n);
    check("div0_nstall", 64'(n), 64'd1);
    check("div0_lo", 64'(lo), 64'hFFFFFFFF);
    check("div0_hi", 64'(hi), 64'd100);

    // flush arriving in the DONE cycle cannot undo a committed result
    ex_mdop = OP_DIV; ex_a = 32'd55; ex_b = 32'd0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ex_mdop = OP_NONE;
    check("div0_flushdone_hi", 64'(hi), 64'd55);

    run_op(OP_MTHI, 32'h1234, 32'd0, n);
    check("mthi_nstall", 64'(n), 64'd0);
    run_op(OP_MTLO, 32'h5678, 32'd0, n);
    check("mtlo_nstall", 64'(n), 64'd0);
    check("mt_hi", 64'(hi), 64'h1234);
    check("mt_lo", 64'(lo), 64'h5678);

    d0 = done_cnt;
    ex_mdop = OP_DIVU; ex_a = 32'd1000; ex_b = 32'd7;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    #2 check("flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; ex_mdop = OP_NONE;
    repeat (3) begin @(posedge clk); #1; end
    check("flush_hi", 64'(hi), 64'h1234);
    check("flush_lo", 64'(lo), 64'h5678);
    check("flush_nodone", 64'(done_cnt), 64'(d0));
    check("flush_idle_stall", 64'(stall), 64'd0);

    ex_mdop = OP_MULTU; ex_a = 32'd5; ex_b = 32'd6;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check("rstmid_stall", 64'(stall), 64'd0);
    check("rstmid_hi", 64'(hi), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    ex_mdop = OP_NONE;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    d0 = done_cnt;
    run_op(OP_MULTU, 32'd3, 32'd4, n);
    check("post_rst_nstall", 64'(n), 64'(MUL_STALL));
    check("post_rst_lo", 64'(lo), 64'd12);
    check("post_rst_hi", 64'(hi), 64'd0);
    check("post_rst_done", 64'(done_cnt - d0), 64'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, consuming operands and operation code registered by the ID/EX pipeline register. It computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers and drives a stall back to the front of the pipeline so that ID/EX and earlier stages hold while an operation is in flight. MTHI/MTLO writes and HI/LO reads for MFHI/MFLO are also handled here.

## Interface
Parameters:
- `ITER`, 32: iterations per multiply/divide; fixed by the 32-bit operand width.

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ex_a`  in  32  operand A: multiplicand, dividend, or MTHI/MTLO source
- `ex_b`  in  32  operand B: multiplier or divisor
- `ex_mdop`  in  3  op: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
- `flush`  in  1  kill the instruction currently in EX
- `stall`  out  1  hold IF/ID and ID/EX this cycle
- `done`  out  1  one-cycle pulse: HI/LO updated by mul/div
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, BUSY, DONE. Internal regs: 5-bit `cnt`, 64-bit accumulator/remainder-quotient, operand magnitudes, sign flags.
- IDLE: if `ex_mdop` is a mul/div and `flush`=0: latch operands (magnitudes for signed ops, sign of result/remainder), `cnt`<=0, go to BUSY. MTHI/MTLO write `hi`/`lo` from `ex_a` at this edge, with no stall, and remain in IDLE.
- BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. At `cnt`=ITER-1, apply sign correction, write `hi`/`lo`, and go to DONE.
- DONE: `done`=1 and `stall`=0, so the instruction leaves EX at this edge; `ex_mdop` is ignored. Go to IDLE.
- Multiply: `{hi,lo}` = 64-bit product. Signed results are negated in 64 bits when the operand signs differ.
- Divide: `lo` = quotient, `hi` = remainder. Signed: quotient is negated if signs differ; remainder takes the dividend's sign. 0x80000000 / -1 gives `lo`=0x80000000, `hi`=0.
- Divide by zero is detected in IDLE: go directly to DONE next edge with `lo`=0xFFFFFFFF and `hi`=`ex_a`, for both DIV and DIVU.
- `flush` in IDLE (issue cycle) or BUSY: abort, go to IDLE, leave `hi`/`lo` unchanged, no `done`. `flush` in DONE: no effect, because the result is already committed.
- `stall` = `rst` & !`flush` & ((IDLE & mul/div op & not divide-by-zero-fast-path-complete) | BUSY). Divide-by-zero stalls for 1 cycle.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `cnt`=0, `hi`=0, `lo`=0, `done`=0, `stall` forced 0.
- Iterative mul/div: issue cycle plus 32 BUSY cycles, so `stall` is high for 33 cycles. DONE is the 34th cycle.
- `hi`/`lo` are valid from the DONE cycle. A dependent MFHI/MFLO in ID is naturally held by `stall`.
- Reset mid-operation returns to the reset values immediately; the result is discarded.
- `stall` is combinational from state, `ex_mdop`, `flush` and `rst`. All other outputs are registered.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MULT/MULTU compute the full product with a single-cycle multiplier at the issue edge and go directly to DONE. `stall` is high 1 cycle and `done` follows next cycle. Divides are unchanged.
- Undefined: all multiplies are iterative, with the 33-cycle stall above.

## Structure
- Package `muldiv_pkg`: `ex_mdop` encodings, state enum (IDLE/BUSY/DONE), `ITER`, divide-by-zero constant 0xFFFFFFFF.
- Sub-module `ex_muldiv_core`: combinational single-step datapath (shift-add or restoring subtract on the 64-bit accumulator). The top level holds the FSM, counter, sign handling and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `stall` high 33 cycles, `done` on cycle 34, `hi`=0xFFFFFFFE, `lo`=0x00000001. With `MULDIV_FAST_MUL_EN`: `stall` high 1 cycle, same result.
- MULT -3 × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV -7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU 100 / 0 -> `stall` 1 cycle, `lo`=0xFFFFFFFF, `hi`=100.
- MTHI 0x1234 then MTLO 0x5678 on back-to-back cycles -> `stall` never high, `hi`=0x1234, `lo`=0x5678. Then `flush` on BUSY cycle 10 of a DIVU -> `stall` drops that cycle, state IDLE, `hi`/`lo` still 0x1234/0x5678, no `done`.
- `rst` low on BUSY cycle 5 -> `stall`=0, `hi`=`lo`=0 immediately. After release, the next MULTU 3×4 gives `lo`=12 after a full 34-cycle sequence.
